// File: rtl/usb_linestate_logger.sv
// usb_linestate_logger: glitch-filtered USB D+/D- line-state change logger feeding buart through a byte FIFO.
// Define LINESTATE_OVF_MARK_EN to append a "!" marker to the stream after events were dropped.
module usb_linestate_logger #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FIFO_AW       = 4,
    parameter logic [23:0] ACT_CYCLES    = 24'd1200000
) (
    input  logic       CLK,
    input  logic       RESETQ,
    input  logic       USB_DP,
    input  logic       USB_DM,
    input  logic       uart_busy,
    output logic       uart_wr,
    output logic [7:0] tx_data,
    output logic [1:0] line_state,
    output logic       overflow,
    output logic       ACTIVITY
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STABLE  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, STROBE, GUARD} tx_state_e;

    logic [1:0]       sync1_q, sync2_q, cand_q, cand_d, line_q, line_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ev;
    logic [7:0]       ev_code, push_data, head;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]       mem_q [2**FIFO_AW];
    logic             full, empty, pop, push, drop;
    logic             ovf_q, ovf_d;
    tx_state_e        state_q, state_d;
    logic             uart_wr_q, uart_wr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [23:0]      act_q, act_d;
`ifdef LINESTATE_OVF_MARK_EN
    logic             mark_q, mark_d, mark_push;
`endif

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        line_d = line_q;
        ev     = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = CNT_ONE;
        end else if (cand_q != line_q) begin
            if (cnt_q >= STABLE - CNT_ONE) begin
                line_d = cand_q;
                ev     = 1'b1;
            end
            if (cnt_q != STABLE) cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign ev_code = (cand_q == 2'b00) ? 8'h30 :
                     (cand_q == 2'b10) ? 8'h70 :
                     (cand_q == 2'b01) ? 8'h6D : 8'h31;

    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign empty = wr_ptr_q == rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign pop   = (state_q == IDLE) && !empty && !uart_busy;
    // A pop on the same edge frees a slot, so a push at full is still accepted.
    assign drop  = ev && full && !pop;

    always_comb begin
`ifdef LINESTATE_OVF_MARK_EN
        mark_push = mark_q && !ev && !full;
        push      = (ev && (!full || pop)) || mark_push;
        push_data = ev ? ev_code : 8'h21;
        mark_d    = (mark_q && !mark_push) || drop;
`else
        push      = ev && (!full || pop);
        push_data = ev_code;
`endif
        wr_ptr_d  = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        ovf_d     = ovf_q || drop;
        state_d   = (state_q == IDLE) ? (pop ? STROBE : IDLE) :
                    (state_q == STROBE) ? GUARD : IDLE;
        uart_wr_d = pop;
        tx_data_d = pop ? head : tx_data_q;
        act_d     = ev ? ACT_CYCLES : (act_q != 24'd0) ? act_q - 24'd1 : act_q;
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
    end

    always_ff @(posedge CLK or negedge RESETQ) begin
        if (!RESETQ) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            cand_q    <= 2'b00;
            cnt_q     <= '0;
            line_q    <= 2'b00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            uart_wr_q <= 1'b0;
            tx_data_q <= 8'h00;
            act_q     <= 24'd0;
`ifdef LINESTATE_OVF_MARK_EN
            mark_q    <= 1'b0;
`endif
        end else begin
            sync1_q   <= {USB_DP, USB_DM};
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            uart_wr_q <= uart_wr_d;
            tx_data_q <= tx_data_d;
            act_q     <= act_d;
`ifdef LINESTATE_OVF_MARK_EN
            mark_q    <= mark_d;
`endif
        end
    end

    assign uart_wr    = uart_wr_q;
    assign tx_data    = tx_data_q;
    assign line_state = line_q;
    assign overflow   = ovf_q;
    assign ACTIVITY   = act_q != 24'd0;
endmodule

// File: doc/usb_linestate_logger.md
# usb_linestate_logger

Parametrised USB line-state monitor for the slowworm PMOD. It samples USB_DP/USB_DM, filters glitches and classifies the bus into SE0/J-like/K-like/SE1. Each accepted state change is queued as one ASCII event byte in a FIFO and drained into the existing buart transmit port under a busy handshake. It replaces per-cycle "p"/"m" polling with change-only, lossless-until-full reporting, and drives the ACTIVITY LED.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronised samples required to accept a new line state (1..255)
- FIFO_AW, 4: FIFO address width; depth = 2^FIFO_AW entries of 8 bits
- ACT_CYCLES, 24'd1200000: ACTIVITY stretch length in CLK cycles per event
- CLK  in  1  system clock
- RESETQ  in  1  asynchronous active-low reset
- USB_DP  in  1  raw D+ pin, asynchronous
- USB_DM  in  1  raw D- pin, asynchronous
- uart_busy  in  1  buart transmitter busy
- uart_wr  out  1  one-cycle write strobe to buart
- tx_data  out  8  byte presented with uart_wr, held until next strobe
- line_state  out  2  accepted state {DP,DM}
- overflow  out  1  sticky: an event was dropped because FIFO full
- ACTIVITY  out  1  stretched pulse on each accepted event

## Operation
- Synchroniser: two flops per pin, sampled on CLK; filter operates on second-stage outputs.
- Filter: candidate register plus counter (width ceil(log2(STABLE_CYCLES+1))). Sample differs from candidate -> candidate := sample, count := 1. Sample equals candidate and differs from line_state -> count increments; when count reaches STABLE_CYCLES, line_state := candidate and one event is generated. Counter saturates; no event when candidate equals line_state.
- Event codes by new {DP,DM}: 00 -> "0" (8'h30), 10 -> "p" (8'h70), 01 -> "m" (8'h6D), 11 -> "1" (8'h31).
- FIFO: 2^FIFO_AW entries, FIFO_AW+1-bit read/write pointers; full when addresses equal and MSBs differ, empty when pointers equal. Push on event when not full; push while full is dropped and sets overflow. overflow clears only on reset.
- Simultaneous push and pop on the same cycle are both honoured, including at full (pop frees the slot, push accepted) and at empty (push not visible to pop until next cycle).
- Transmit FSM: IDLE -> when FIFO non-empty and uart_busy low: tx_data := head, uart_wr := 1, pop, go STROBE. STROBE -> uart_wr := 0, go GUARD. GUARD -> one cycle unconditionally, then IDLE. GUARD absorbs buart's one-cycle busy lag; no strobe ever issued while uart_busy is high.
- ACTIVITY: counter loaded with ACT_CYCLES on each accepted event (reload if already running); ACTIVITY = counter non-zero.

## Timing
- Reset values: uart_wr 0, tx_data 8'h00, line_state 2'b00, overflow 0, ACTIVITY 0, FIFO empty, FSM IDLE, candidate 2'b00, count 0. Reset state SE0 emits no event.
- Pin edge to line_state update: 2 sync cycles + STABLE_CYCLES cycles.
- line_state update to FIFO entry: same edge (event pushes on the cycle line_state changes).
- FIFO entry to uart_wr: 1 cycle minimum when IDLE and uart_busy low.
- Minimum strobe spacing: 3 cycles; actual spacing governed by uart_busy.
- Reset asserted mid-transfer: FSM to IDLE, FIFO flushed, uart_wr low immediately; byte already in buart not affected.

## Configuration
- LINESTATE_OVF_MARK_EN defined: when a push is dropped, a pending-mark flag is set; the first cycle the FIFO is not full and no event is being pushed, "!" (8'h21) is pushed and the flag cleared. A coinciding event has priority; mark retries next cycle. overflow still sticky.
- Not defined: drops are only signalled by overflow; no marker in the stream; pending-mark logic absent.

## Test plan
- Reset, pins 00 idle 100 cycles -> no uart_wr, line_state 00, ACTIVITY 0.
- DP 0->1 held 10 cycles, STABLE_CYCLES=4, uart_busy 0 -> line_state 10 at cycle 6 after edge, one uart_wr with tx_data 8'h70 next cycle, ACTIVITY high.
- DP glitch high for 3 cycles with STABLE_CYCLES=4 -> no state change, no strobe.
- uart_busy held high, 20 alternating DP/DM changes, FIFO_AW=4 -> 16 bytes queued in order, overflow=1; release busy -> exactly 16 strobes in order; with LINESTATE_OVF_MARK_EN, 8'h21 follows the 16th byte.
- uart_busy pulsed high 1 cycle after each strobe for 50 cycles -> next strobe never while busy high, strobe spacing ≥3 cycles.
- RESETQ low during GUARD with 5 bytes queued -> uart_wr 0, FIFO empty, no further strobes after release.
